// File: rtl/instr_encoder_loader_if.sv
// Request/instruction-memory bundle for the RV32I encoder/loader.
// The master side issues encode requests; the slave side drives the memory write port.
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic              ALUD;
  logic              RegW;
  logic              ALUSrc;
  logic              MemW;
  logic              MemRd;
  logic              Jalr;
  logic              Branch;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        F;
  logic              f7b5;
  logic [11:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              illegal;

  modport master (
    output in_valid, ALUD, RegW, ALUSrc, MemW, MemRd, Jalr, Branch,
           rd, rs1, rs2, F, f7b5, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, illegal
  );

  modport slave (
    input  in_valid, ALUD, RegW, ALUSrc, MemW, MemRd, Jalr, Branch,
           rd, rs1, rs2, F, f7b5, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, illegal
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes main-decoder control flags plus fields into an RV32I word and
// writes it to instruction memory at an auto-incrementing word address.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  clr,
  instr_encoder_loader_if.slave bus
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  state_t            state;
  logic              we_q;
  logic              illegal_q;
  logic              full_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic              legal;
  logic [31:0]       enc;

  // Class priority mirrors the main decoder; first matching class wins.
  always_comb begin
    legal = 1'b1;
    enc   = 32'h0;
    if (bus.MemW) begin
      enc = {bus.imm[11:5], bus.rs2, bus.rs1, bus.F, bus.imm[4:0], OP_STORE};
    end else if (bus.Jalr) begin
      enc = {bus.imm, bus.rs1, 3'b000, bus.rd, OP_JALR};
    end else if (bus.Branch) begin
      // imm holds offset[12:1], so offset[11] sits at imm[10]
      enc = {bus.imm[11], bus.imm[9:4], bus.rs2, bus.rs1, bus.F,
             bus.imm[3:0], bus.imm[10], OP_BRANCH};
    end else if (bus.ALUD && !bus.ALUSrc) begin
      enc = {1'b0, bus.f7b5, 5'b00000, bus.rs2, bus.rs1, bus.F, bus.rd, OP_R};
    end else if (bus.RegW && bus.ALUSrc && bus.MemRd) begin
      enc = {bus.imm, bus.rs1, bus.F, bus.rd, OP_LOAD};
    end else if (bus.RegW && bus.ALUSrc) begin
      // Shift-immediates carry funct7 above a 5-bit shamt
      if (bus.F == 3'b001 || bus.F == 3'b101) begin
        enc = {1'b0, bus.f7b5, 5'b00000, bus.imm[4:0], bus.rs1, bus.F, bus.rd, OP_IALU};
      end else begin
        enc = {bus.imm, bus.rs1, bus.F, bus.rd, OP_IALU};
      end
    end else begin
      legal = 1'b0;
    end
  end

  assign bus.in_ready = (state == IDLE) && !clr;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      full_q    <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wdata_q   <= 32'h0;
    end else begin
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (legal) begin
              state   <= WRITE;
              we_q    <= 1'b1;
              wdata_q <= enc;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Last slot: park the address rather than wrap
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state  <= FULL;
            full_q <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            state  <= IDLE;
          end
        end
        FULL:    state <= FULL;
        default: state <= IDLE;
      endcase
    end
  end

  // A reset or clear arriving in the WRITE cycle must kill that write immediately.
  assign bus.mem_we    = we_q && !rst && !clr;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.count     = cnt_q;
  assign bus.full      = full_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encodings, handshake timing,
// illegal rejection, fill-to-full, and clr/rst during a write.
module tb_instr_encoder_loader;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 4;

  localparam logic [6:0] FL_ALUD   = 7'b1000000;
  localparam logic [6:0] FL_REGW   = 7'b0100000;
  localparam logic [6:0] FL_ALUSRC = 7'b0010000;
  localparam logic [6:0] FL_MEMW   = 7'b0001000;
  localparam logic [6:0] FL_MEMRD  = 7'b0000100;
  localparam logic [6:0] FL_JALR   = 7'b0000010;
  localparam logic [6:0] FL_BRANCH = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [6:0]  fl;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f;
    logic        f7b5;
    logic [11:0] imm;
    logic [31:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [6:0] fl, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f, input logic f7b5,
                         input logic [11:0] imm);
    {bus.ALUD, bus.RegW, bus.ALUSrc, bus.MemW, bus.MemRd, bus.Jalr, bus.Branch} = fl;
    bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.F = f; bus.f7b5 = f7b5; bus.imm = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; bus.in_valid = 1'b0;
    set_req(7'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 12'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_checks++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_r_type();
    set_req(FL_ALUD | FL_REGW, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 12'd0);
    bus.in_valid = 1'b1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL r_ready_idle: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL r_we: got %b want 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 3'd0) begin n_fail++; $display("FAIL r_addr: got %0d want 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h002081B3) begin n_fail++; $display("FAIL r_wdata: got %h want 002081b3", bus.mem_wdata); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL r_ready_write: got %b want 0", bus.in_ready); end
    tick();
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL r_we_drop: got %b want 0", bus.mem_we); end
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL r_count: got %0d want 1", bus.count); end
  endtask

  task automatic test_store();
    set_req(FL_MEMW | FL_ALUSRC, 5'd0, 5'd2, 5'd5, 3'b010, 1'b0, 12'd8);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b want 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 3'd1) begin n_fail++; $display("FAIL sw_addr: got %0d want 1", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h00512423) begin n_fail++; $display("FAIL sw_wdata: got %h want 00512423", bus.mem_wdata); end
    tick();
    n_checks++; if (bus.count !== 4'd2) begin n_fail++; $display("FAIL sw_count: got %0d want 2", bus.count); end
  endtask

  task automatic test_back_to_back();
    set_req(FL_REGW | FL_ALUSRC, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 12'd5);
    bus.in_valid = 1'b1;
    tick();
    // jalr presented while the addi write is in flight; must wait a cycle
    set_req(FL_JALR | FL_REGW | FL_ALUSRC, 5'd1, 5'd6, 5'd0, 3'b000, 1'b0, 12'd0);
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_addi_we: got %b want 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 3'd2) begin n_fail++; $display("FAIL b2b_addi_addr: got %0d want 2", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h00500093) begin n_fail++; $display("FAIL b2b_addi_wdata: got %h want 00500093", bus.mem_wdata); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_addi_ready: got %b want 0", bus.in_ready); end
    tick();
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_we: got %b want 0", bus.mem_we); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL b2b_gap_count: got %0d want 3", bus.count); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_jalr_we: got %b want 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 3'd3) begin n_fail++; $display("FAIL b2b_jalr_addr: got %0d want 3", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h000300E7) begin n_fail++; $display("FAIL b2b_jalr_wdata: got %h want 000300e7", bus.mem_wdata); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_jalr_ready: got %b want 0", bus.in_ready); end
    tick();
    n_checks++; if (bus.count !== 4'd4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", bus.count); end
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL b2b_full: got %b want 1", bus.full); end
  endtask

  task automatic test_full();
    set_req(FL_ALUD | FL_REGW, 5'd7, 5'd7, 5'd7, 3'b000, 1'b0, 12'd0);
    bus.in_valid = 1'b1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", bus.in_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL full_no_write%0d: got %b want 0", i, bus.mem_we); end
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.count !== 4'd4) begin n_fail++; $display("FAIL full_count_hold: got %0d want 4", bus.count); end
    clr = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_low: got %b want 0", bus.in_ready); end
    tick();
    clr = 1'b0;
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.mem_addr !== 3'd0) begin n_fail++; $display("FAIL clr_addr: got %0d want 0", bus.mem_addr); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL clr_full: got %b want 0", bus.full); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_illegal();
    logic [6:0] bad [2];
    bad[0] = 7'b0;
    bad[1] = FL_ALUD | FL_ALUSRC;
    for (int i = 0; i < 2; i++) begin
      set_req(bad[i], 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 12'h123);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.illegal !== 1'b1) begin n_fail++; $display("FAIL ill%0d_pulse: got %b want 1", i, bus.illegal); end
      n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL ill%0d_we: got %b want 0", i, bus.mem_we); end
      tick();
      n_checks++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL ill%0d_drop: got %b want 0", i, bus.illegal); end
      n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL ill%0d_count: got %0d want 0", i, bus.count); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ill%0d_ready: got %b want 1", i, bus.in_ready); end
    end
  endtask

  task automatic test_encodings();
    vec_t v [4];
    v[0] = '{FL_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 12'h004, 32'h00208463};
    v[1] = '{FL_REGW | FL_ALUSRC, 5'd5, 5'd6, 5'd0, 3'b101, 1'b1, 12'h003, 32'h40335293};
    v[2] = '{FL_REGW | FL_ALUSRC | FL_MEMRD, 5'd7, 5'd8, 5'd0, 3'b010, 1'b0, 12'hFFC, 32'hFFC42383};
    v[3] = '{FL_BRANCH, 5'd9, 5'd3, 5'd4, 3'b001, 1'b0, 12'hFFF, 32'hFE419FE3};
    for (int i = 0; i < 4; i++) begin
      set_req(v[i].fl, v[i].rd, v[i].rs1, v[i].rs2, v[i].f, v[i].f7b5, v[i].imm);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL enc%0d_we: got %b want 1", i, bus.mem_we); end
      n_checks++; if (bus.mem_addr !== 3'(i)) begin n_fail++; $display("FAIL enc%0d_addr: got %0d want %0d", i, bus.mem_addr, i); end
      n_checks++; if (bus.mem_wdata !== v[i].exp) begin n_fail++; $display("FAIL enc%0d_wdata: got %h want %h", i, bus.mem_wdata, v[i].exp); end
      tick();
      n_checks++; if (bus.count !== 4'(i + 1)) begin n_fail++; $display("FAIL enc%0d_count: got %0d want %0d", i, bus.count, i + 1); end
    end
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL enc_full: got %b want 1", bus.full); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
  endtask

  task automatic test_clr_during_write();
    set_req(FL_REGW | FL_ALUSRC, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 12'd5);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL cw_we_pre: got %b want 1", bus.mem_we); end
    clr = 1'b1;
    #1;
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL cw_we_suppressed: got %b want 0", bus.mem_we); end
    tick();
    clr = 1'b0;
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL cw_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.mem_addr !== 3'd0) begin n_fail++; $display("FAIL cw_addr: got %0d want 0", bus.mem_addr); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL cw_we_after: got %b want 0", bus.mem_we); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL cw_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_rst_during_write();
    set_req(FL_ALUD | FL_REGW, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 12'd0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.mem_wdata !== 32'h002081B3) begin n_fail++; $display("FAIL rw_wdata_pre: got %h want 002081b3", bus.mem_wdata); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rw_we_suppressed: got %b want 0", bus.mem_we); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rw_we: got %b want 0", bus.mem_we); end
    n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rw_wdata: got %h want 0", bus.mem_wdata); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rw_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.mem_addr !== 3'd0) begin n_fail++; $display("FAIL rw_addr: got %0d want 0", bus.mem_addr); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rw_ready: got %b want 1", bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_store();
    test_back_to_back();
    test_full();
    test_illegal();
    test_encodings();
    test_clr_during_write();
    test_rst_during_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
